// File: rtl/ip_cart_mem_arbiter_pkg.sv
// ip_cart_mem_arbiter_pkg
//   Shared definitions for the cartridge memory arbiter: FSM state
//   encoding and the supported memory read latency range.
package ip_cart_mem_arbiter_pkg;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;
  localparam int LAT_CNT_W   = 2;

  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_BUS_ACC  = 3'd1;
  localparam logic [2:0] ENC_BUS_WAIT = 3'd2;
  localparam logic [2:0] ENC_LD_ACC   = 3'd3;
  localparam logic [2:0] ENC_LD_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ENC_IDLE,
    BUS_ACC  = ENC_BUS_ACC,
    BUS_WAIT = ENC_BUS_WAIT,
    LD_ACC   = ENC_LD_ACC,
    LD_WAIT  = ENC_LD_WAIT
  } state_t;

endpackage

// File: rtl/ip_cart_mem_arbiter_if.sv
// ip_cart_mem_arbiter_if
//   Signal bundle around the arbiter: cartridge bus side (active-low
//   strobes, mapped address, read data return), image loader request/ack
//   side and the single-port memory macro side.
//   slave  : arbiter view
//   master : environment view (wrapper, loader and memory)
interface ip_cart_mem_arbiter_if #(
  parameter int ADDR_W = 14
);

  logic              bus_n_cs;
  logic              bus_n_rd;
  logic              bus_n_wr;
  logic [ADDR_W-1:0] bus_address;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;
  logic              bus_rdata_en;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_address;
  logic [7:0]        ld_wdata;
  logic              ld_ack;
  logic [7:0]        ld_rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  bus_n_cs, bus_n_rd, bus_n_wr, bus_address, bus_wdata,
    output bus_rdata, bus_rdata_en,
    input  ld_req, ld_we, ld_address, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_cs, mem_we, mem_address, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output bus_n_cs, bus_n_rd, bus_n_wr, bus_address, bus_wdata,
    input  bus_rdata, bus_rdata_en,
    output ld_req, ld_we, ld_address, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_cs, mem_we, mem_address, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/ip_cart_mem_arbiter_bus_req_detect.sv
// ip_bus_req_detect
//   Brings the asynchronous cartridge strobes into the clk domain through
//   2-flop synchronisers and produces one request pulse per bus cycle.
//   Ports:
//     clk, n_reset       clock, synchronous active-low reset
//     n_cs, n_rd, n_wr   raw active-low bus strobes
//     req                1-cycle pulse on inactive -> active transition
//     we                 synchronised write strobe (valid with req)
//     strobe_active      synchronised n_cs=0 and (n_rd=0 or n_wr=0)
module ip_bus_req_detect (
  input  logic clk,
  input  logic n_reset,
  input  logic n_cs,
  input  logic n_rd,
  input  logic n_wr,
  output logic req,
  output logic we,
  output logic strobe_active
);

  logic [1:0] cs_sync;
  logic [1:0] rd_sync;
  logic [1:0] wr_sync;
  logic       active_q;

  // Synchronisers reset to the inactive (high) strobe level.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cs_sync  <= 2'b11;
      rd_sync  <= 2'b11;
      wr_sync  <= 2'b11;
      active_q <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[0], n_cs};
      rd_sync  <= {rd_sync[0], n_rd};
      wr_sync  <= {wr_sync[0], n_wr};
      active_q <= strobe_active;
    end
  end

  assign strobe_active = !cs_sync[1] && (!rd_sync[1] || !wr_sync[1]);
  assign we            = !wr_sync[1];
  assign req           = strobe_active && !active_q;

endmodule

// File: rtl/ip_cart_mem_arbiter.sv
// ip_cart_mem_arbiter
//   Shares one single-port memory between the cartridge bus (strict
//   priority) and the background image loader (idle slots). One memory
//   access per grant; mem_cs is never asserted on consecutive cycles.
//   Ports:
//     clk, n_reset   clock, synchronous active-low reset
//     arb            ip_cart_mem_arbiter_if.slave (bus, loader, memory)
//   Parameters:
//     ADDR_W         memory byte address width
//     MEM_LATENCY    cycles from mem_cs to valid mem_rdata (1..3)
//   Build option:
//     CART_ARB_ROM_WP_EN  when defined, bus writes to the ROM half
//                         (address MSB = 0) are dropped.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | no access; bus request first, then loader
//   BUS_ACC  | memory strobe with captured bus fields
//   BUS_WAIT | waiting for bus read data, then return it
//   LD_ACC   | memory strobe with loader fields
//   LD_WAIT  | waiting for loader read data, then ack
module ip_cart_mem_arbiter
  import ip_cart_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int MEM_LATENCY = 2
) (
  input logic                  clk,
  input logic                  n_reset,
  ip_cart_mem_arbiter_if.slave arb
);

  if (MEM_LATENCY < MEM_LAT_MIN || MEM_LATENCY > MEM_LAT_MAX) begin : g_bad_latency
    $error("ip_cart_mem_arbiter: MEM_LATENCY must be 1..3");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 bus_pend;
  logic [ADDR_W-1:0]    cap_address;
  logic [7:0]           cap_wdata;
  logic                 cap_we;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 req;
  logic                 req_we;
  logic                 strobe_active;
  logic                 rd_hold;
  logic                 bus_done;
  logic                 bus_wp;

  ip_bus_req_detect u_req_detect (
    .clk           (clk),
    .n_reset       (n_reset),
    .n_cs          (arb.bus_n_cs),
    .n_rd          (arb.bus_n_rd),
    .n_wr          (arb.bus_n_wr),
    .req           (req),
    .we            (req_we),
    .strobe_active (strobe_active)
  );

  // A read cycle is still open while the synchronised strobes show a
  // read; a cycle that already ended gets no read data.
  assign rd_hold  = strobe_active && !req_we;
  assign bus_done = (state == BUS_WAIT) && (lat_cnt == '0);

`ifdef CART_ARB_ROM_WP_EN
  assign bus_wp = cap_we && !cap_address[ADDR_W-1];
`else
  assign bus_wp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state            <= IDLE;
      bus_pend         <= 1'b0;
      cap_address      <= '0;
      cap_wdata        <= '0;
      cap_we           <= 1'b0;
      lat_cnt          <= '0;
      arb.bus_rdata    <= '0;
      arb.bus_rdata_en <= 1'b0;
    end else begin
      state <= state_nxt;

      // A new request overwrites older captured fields.
      if (req) begin
        bus_pend    <= 1'b1;
        cap_address <= arb.bus_address;
        cap_wdata   <= arb.bus_wdata;
        cap_we      <= req_we;
      end else if (state == BUS_ACC) begin
        bus_pend <= 1'b0;
      end

      if (state == BUS_ACC || state == LD_ACC) begin
        lat_cnt <= LAT_LOAD;
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
      end

      if (bus_done && rd_hold) begin
        arb.bus_rdata    <= arb.mem_rdata;
        arb.bus_rdata_en <= 1'b1;
      end else if (!rd_hold) begin
        arb.bus_rdata    <= '0;
        arb.bus_rdata_en <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    arb.mem_cs      = 1'b0;
    arb.mem_we      = 1'b0;
    arb.mem_address = '0;
    arb.mem_wdata   = '0;
    arb.ld_ack      = 1'b0;
    arb.ld_rdata    = '0;

    case (state)
      IDLE: begin
        // req is checked alongside bus_pend so a request arriving in the
        // same cycle as ld_req still wins.
        if (bus_pend || req) begin
          state_nxt = BUS_ACC;
        end else if (arb.ld_req) begin
          state_nxt = LD_ACC;
        end
      end

      BUS_ACC: begin
        if (!bus_wp) begin
          arb.mem_cs      = 1'b1;
          arb.mem_we      = cap_we;
          arb.mem_address = cap_address;
          arb.mem_wdata   = cap_wdata;
        end
        state_nxt = cap_we ? IDLE : BUS_WAIT;
      end

      BUS_WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = IDLE;
        end
      end

      LD_ACC: begin
        arb.mem_cs      = 1'b1;
        arb.mem_we      = arb.ld_we;
        arb.mem_address = arb.ld_address;
        arb.mem_wdata   = arb.ld_wdata;
        if (arb.ld_we) begin
          arb.ld_ack = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = LD_WAIT;
        end
      end

      LD_WAIT: begin
        if (lat_cnt == '0) begin
          arb.ld_ack   = 1'b1;
          arb.ld_rdata = arb.mem_rdata;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
